// File: rtl/addsub_share_arb.sv
// addsub_share_arb
//   Round-robin arbiter that time-shares one registered "A + B + 1" stage
//   between NREQ requesters. One operation is in flight at a time:
//   IDLE (grant/capture) -> EXEC (add) -> RESP (hold result until taken).
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid[NREQ]   per-requester operand valid
//   req_ready[NREQ]   one-hot grant, only in IDLE, combinational
//   req_a/req_b       packed operands, slice i = [i*WIDTH +: WIDTH]
//   rsp_valid/ready   result handshake
//   rsp_data          A + B + 1 mod 2^WIDTH
//   rsp_id            requester index that owns rsp_data
//   busy              high whenever the FSM is not IDLE
module addsub_share_arb #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   id;
  logic [WIDTH-1:0] op_a, op_b;

  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic             accept;

  // Rotating priority scan: first valid requester at or after last+1.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last) + 1 + k) % NREQ;
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  assign accept = (state_q == IDLE) && win_vld;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last      <= IDW'(NREQ - 1);
      id        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a <= req_a[int'(win_id)*WIDTH +: WIDTH];
        op_b <= req_b[int'(win_id)*WIDTH +: WIDTH];
        id   <= win_id;
        last <= win_id;
      end
      if (state_q == EXEC) begin
        // Carry-out intentionally dropped: result wraps mod 2^WIDTH.
        rsp_data  <= op_a + op_b + WIDTH'(1);
        rsp_id    <= id;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        // Data/id are left holding the last result.
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/addsub_share_arb.md
Name: addsub_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one registered "A + B + 1" adder stage between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester, captures its operands, runs the adder for one cycle, then holds the tagged result on a single response channel until it is consumed.
- Sits between the pin-level input mux and the shared arithmetic unit in the top-level design.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 8, operand and result width in bits.
- IDW, $clog2(NREQ) with minimum 1, width of the requester tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept; at most one bit high.
- req_a  input  NREQ*WIDTH  operand A; slice i is bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; sliced the same way.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WIDTH  result = A + B + 1 mod 2^WIDTH.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n). Reset is sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE; rsp_valid = 0; rsp_data = 0; rsp_id = 0; busy = 0; req_ready = 0 until a request is present.
  - Round-robin pointer last = NREQ-1, so requester 0 has top priority first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational.
  - The winner is the first i with req_valid[i]=1, scanning from (last+1) mod NREQ upward with wrap.
  - Only the winner's req_ready bit is high. All bits are 0 when no request is valid.
  - On an edge with req_valid[w] & req_ready[w]: capture req_a/req_b slices into operand registers, capture id=w, set last=w, go to EXEC.
- EXEC: req_ready = 0. At the next edge, rsp_data <= op_a + op_b + 1 (carry-out discarded, no saturation), rsp_id <= id, rsp_valid <= 1, go to RESP.
- RESP:
  - req_ready = 0. rsp_valid, rsp_data and rsp_id stay stable until an edge with rsp_ready=1.
  - At that edge, rsp_valid <= 0 and state goes to IDLE.
  - rsp_data and rsp_id keep their last value after the handshake. They are not cleared.
- Latency: acceptance at edge T0 gives rsp_valid high from T0+2. With rsp_ready tied high, the earliest next acceptance is T0+3 (one op per 3 cycles).
- No pipelining: a new request is never accepted in EXEC or RESP.
- Requesters may drop req_valid before being granted. There is no side effect and the pointer does not move.
- Operands are sampled only on the accept edge. Later changes on req_a/req_b have no effect.
- rsp_ready high while rsp_valid=0 is ignored.
- Simultaneous requests: round-robin guarantees that each continuously valid requester is served within NREQ grants.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped with no response, and all reset values are restored at that edge.
- When reset is released, the first grant follows the reset pointer (requester 0 first).

Test Plan:
- Single op: req 0 valid with A=0x10, B=0x20, rsp_ready=1. Required: req_ready[0]=1 in the accept cycle, rsp_valid high 2 cycles after acceptance, rsp_data=0x31, rsp_id=0, busy high for 2 cycles, then IDLE.
- Wrap arithmetic on requester 1 with only it valid:
  - A=0xFF, B=0x00 gives rsp_data=0x00, rsp_id=1.
  - A=0xFF, B=0xFF gives rsp_data=0xFF.
  - A=0x7F, B=0x80 gives rsp_data=0x00.
- Fairness: both requesters continuously valid, requester 0 with (1,1) and requester 1 with (2,2), rsp_ready=1. Required: rsp sequence id 0/0x03, 1/0x05, 0/0x03, 1/0x05, and req_ready never has two bits high.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises. Required: rsp_valid, rsp_data and rsp_id stable, and req_ready=0 on all bits. Raising rsp_ready gives one handshake, then IDLE, and the next acceptance occurs the following cycle.
- Reset mid-op: assert rst_n=0 for one edge while in RESP. Required: rsp_valid=0, busy=0 and rsp_data=0 after that edge. With both requesters valid afterwards, requester 0 is granted first.
- Operand stability: change req_a of the granted requester during EXEC. Required: the result reflects the operand captured at the accept edge.
